bsg_axi_burst_to_axil_bridge: RTL

- Converts full AXI4 slave bursts (id, len, size, burst) into single-beat AXI-Lite master transactions.
- Lets the AXI-Lite DPI host model serve HP-class ports whose DUT masters issue bursts.
- Sits between the DUT's HP master port and the AXI-Lite DPI endpoint in the cosim testbench.
- One transaction in flight; reads and writes are arbitrated round-robin.

---
 rtl/bsg_axi_bridge_pkg.sv | 40 ++++
 rtl/bsg_axi_burst_addr_gen.sv | 32 +++
 rtl/bsg_axi_burst_to_axil_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_axi_bridge_pkg.sv
// Shared types for the AXI burst to AXI-Lite bridge: burst/resp encodings,
// FSM states and the latched burst descriptor.
package bsg_axi_bridge_pkg;

  localparam int bridge_id_width_gp   = 6;
  localparam int bridge_addr_width_gp = 32;
  localparam int bridge_len_width_gp  = 8;

  typedef enum logic [1:0] {
    e_burst_fixed = 2'b00,
    e_burst_incr  = 2'b01,
    e_burst_wrap  = 2'b10,
    e_burst_rsvd  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    e_resp_okay   = 2'b00,
    e_resp_exokay = 2'b01,
    e_resp_slverr = 2'b10,
    e_resp_decerr = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    e_idle, e_wr_beat, e_wr_resp, e_wr_b, e_rd_addr, e_rd_wait, e_rd_send
  } state_e;

  // addr tracks the current beat address, not just the burst start
  typedef struct packed {
    logic [bridge_id_width_gp-1:0]   id;
    logic [bridge_addr_width_gp-1:0] addr;
    logic [bridge_len_width_gp-1:0]  len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
  } burst_s;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; shared by read and write paths.
module bsg_axi_burst_addr_gen
  import bsg_axi_bridge_pkg::*;
  #(parameter int addr_width_p = 32
  , parameter int len_width_p  = 8
  )
  (input  logic [addr_width_p-1:0] addr_i
  , input  logic [len_width_p-1:0]  len_i
  , input  logic [2:0]              size_i
  , input  logic [1:0]              burst_i
  , output logic [addr_width_p-1:0] next_addr_o
  );

  logic [addr_width_p-1:0] step, incr, wrap_mask, wrap_next;
  logic wrap_ok;

  always_comb begin
    step      = addr_width_p'(1) << size_i;
    incr      = addr_i + step;
    wrap_ok   = (len_i == len_width_p'(1)) || (len_i == len_width_p'(3))
             || (len_i == len_width_p'(7)) || (len_i == len_width_p'(15));
    // wrap window is (len+1) beats of 2^size bytes, aligned to its own size
    wrap_mask = ((addr_width_p'(len_i) + addr_width_p'(1)) << size_i) - addr_width_p'(1);
    wrap_next = (addr_i & ~wrap_mask) | (incr & wrap_mask);
    case (burst_i)
      e_burst_fixed: next_addr_o = addr_i;
      e_burst_wrap:  next_addr_o = wrap_ok ? wrap_next : incr;
      default:       next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/bsg_axi_burst_to_axil_bridge.sv
// Splits AXI4 bursts into single-beat AXI-Lite transactions, one burst in
// flight, reads and writes arbitrated round-robin.
module bsg_axi_burst_to_axil_bridge
  import bsg_axi_bridge_pkg::*;
  #(parameter int id_width_p   = bridge_id_width_gp
  , parameter int addr_width_p = bridge_addr_width_gp
  , parameter int data_width_p = 32
  , parameter int len_width_p  = bridge_len_width_gp
  )
  (input  logic                      clk_i
  , input  logic                      reset_i
  , input  logic [id_width_p-1:0]     s_axi_awid_i
  , input  logic [addr_width_p-1:0]   s_axi_awaddr_i
  , input  logic [len_width_p-1:0]    s_axi_awlen_i
  , input  logic [2:0]                s_axi_awsize_i
  , input  logic [1:0]                s_axi_awburst_i
  , input  logic                      s_axi_awvalid_i
  , output logic                      s_axi_awready_o
  , input  logic [data_width_p-1:0]   s_axi_wdata_i
  , input  logic [data_width_p/8-1:0] s_axi_wstrb_i
  , input  logic                      s_axi_wlast_i
  , input  logic                      s_axi_wvalid_i
  , output logic                      s_axi_wready_o
  , output logic [id_width_p-1:0]     s_axi_bid_o
  , output logic [1:0]                s_axi_bresp_o
  , output logic                      s_axi_bvalid_o
  , input  logic                      s_axi_bready_i
  , input  logic [id_width_p-1:0]     s_axi_arid_i
  , input  logic [addr_width_p-1:0]   s_axi_araddr_i
  , input  logic [len_width_p-1:0]    s_axi_arlen_i
  , input  logic [2:0]                s_axi_arsize_i
  , input  logic [1:0]                s_axi_arburst_i
  , input  logic                      s_axi_arvalid_i
  , output logic                      s_axi_arready_o
  , output logic [id_width_p-1:0]     s_axi_rid_o
  , output logic [data_width_p-1:0]   s_axi_rdata_o
  , output logic [1:0]                s_axi_rresp_o
  , output logic                      s_axi_rlast_o
  , output logic                      s_axi_rvalid_o
  , input  logic                      s_axi_rready_i
  , output logic [addr_width_p-1:0]   m_axil_awaddr_o
  , output logic [2:0]                m_axil_awprot_o
  , output logic                      m_axil_awvalid_o
  , input  logic                      m_axil_awready_i
  , output logic [data_width_p-1:0]   m_axil_wdata_o
  , output logic [data_width_p/8-1:0] m_axil_wstrb_o
  , output logic                      m_axil_wvalid_o
  , input  logic                      m_axil_wready_i
  , input  logic [1:0]                m_axil_bresp_i
  , input  logic                      m_axil_bvalid_i
  , output logic                      m_axil_bready_o
  , output logic [addr_width_p-1:0]   m_axil_araddr_o
  , output logic [2:0]                m_axil_arprot_o
  , output logic                      m_axil_arvalid_o
  , input  logic                      m_axil_arready_i
  , input  logic [data_width_p-1:0]   m_axil_rdata_i
  , input  logic [1:0]                m_axil_rresp_i
  , input  logic                      m_axil_rvalid_i
  , output logic                      m_axil_rready_o
  , output logic                      error_o
  );

  state_e                  state_q, state_d;
  burst_s                  burst_q, burst_d;
  logic [len_width_p-1:0]  beat_q, beat_d;
  logic [1:0]              resp_q, resp_d, rresp_q, rresp_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic                    wr_pri_q, wr_pri_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    error_q, error_d;
  logic [addr_width_p-1:0] next_addr;
  logic                    last_beat, rsvd, wr_req, grant_wr, grant_rd, aw_fire, w_fire;

  bsg_axi_burst_addr_gen #(.addr_width_p(addr_width_p), .len_width_p(len_width_p)) addr_gen
    (.addr_i(burst_q.addr), .len_i(burst_q.len), .size_i(burst_q.size)
    ,.burst_i(burst_q.burst), .next_addr_o(next_addr));

  assign last_beat       = (beat_q == burst_q.len);
  assign rsvd            = (burst_q.burst == e_burst_rsvd);
  assign m_axil_awprot_o = 3'b000;
  assign m_axil_arprot_o = 3'b000;
  assign m_axil_awaddr_o = burst_q.addr;
  assign m_axil_araddr_o = burst_q.addr;
  assign m_axil_wdata_o  = s_axi_wdata_i;
  assign m_axil_wstrb_o  = s_axi_wstrb_i;
  assign s_axi_bid_o     = burst_q.id;
  assign s_axi_bresp_o   = resp_q;
  assign s_axi_rid_o     = burst_q.id;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = rresp_q;
  assign s_axi_rlast_o   = last_beat;
  assign error_o         = error_q;

  always_comb begin
    state_d = state_q;  burst_d = burst_q;  beat_d = beat_q;  resp_d = resp_q;
    rresp_d = rresp_q;  rdata_d = rdata_q;  wr_pri_d = wr_pri_q;
    aw_done_d = aw_done_q;  w_done_d = w_done_q;  error_d = error_q;
    s_axi_awready_o = 1'b0;  s_axi_arready_o = 1'b0;  s_axi_wready_o = 1'b0;
    s_axi_bvalid_o  = 1'b0;  s_axi_rvalid_o  = 1'b0;
    m_axil_awvalid_o = 1'b0; m_axil_wvalid_o = 1'b0;  m_axil_bready_o = 1'b0;
    m_axil_arvalid_o = 1'b0; m_axil_rready_o = 1'b0;
    wr_req   = s_axi_awvalid_i && s_axi_wvalid_i;
    grant_wr = 1'b0;  grant_rd = 1'b0;
    aw_fire  = 1'b0;  w_fire   = 1'b0;
    case (state_q)
      e_idle: begin
        grant_wr = wr_req && (wr_pri_q || !s_axi_arvalid_i);
        grant_rd = s_axi_arvalid_i && !grant_wr;
        if (grant_wr || grant_rd) begin
          beat_d    = '0;
          resp_d    = e_resp_okay;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wr_pri_d  = ~wr_pri_q;
        end
        if (grant_wr) begin
          s_axi_awready_o = 1'b1;
          burst_d = '{id: s_axi_awid_i, addr: s_axi_awaddr_i, len: s_axi_awlen_i,
                      size: s_axi_awsize_i, burst: s_axi_awburst_i};
          state_d = e_wr_beat;
        end else if (grant_rd) begin
          s_axi_arready_o = 1'b1;
          burst_d = '{id: s_axi_arid_i, addr: s_axi_araddr_i, len: s_axi_arlen_i,
                      size: s_axi_arsize_i, burst: s_axi_arburst_i};
          state_d = e_rd_addr;
        end
      end
      e_wr_beat: begin
        m_axil_awvalid_o = !aw_done_q;
        m_axil_wvalid_o  = !w_done_q && s_axi_wvalid_i;
        s_axi_wready_o   = m_axil_wready_i && !w_done_q;
        aw_fire = m_axil_awvalid_o && m_axil_awready_i;
        w_fire  = m_axil_wvalid_o && m_axil_wready_i;
        // a misplaced or missing wlast is flagged, but the burst still runs by count
        if (w_fire && (s_axi_wlast_i != last_beat)) error_d = 1'b1;
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = e_wr_resp;
        end
      end
      e_wr_resp: begin
        m_axil_bready_o = 1'b1;
        if (m_axil_bvalid_i) begin
          resp_d = resp_max(resp_q, rsvd ? e_resp_slverr : m_axil_bresp_i);
          if (last_beat) state_d = e_wr_b;
          else begin
            burst_d.addr = next_addr;
            beat_d  = beat_q + len_width_p'(1);
            state_d = e_wr_beat;
          end
        end
      end
      e_wr_b: begin
        s_axi_bvalid_o = 1'b1;
        if (s_axi_bready_i) state_d = e_idle;
      end
      e_rd_addr: begin
        m_axil_arvalid_o = 1'b1;
        if (m_axil_arready_i) state_d = e_rd_wait;
      end
      e_rd_wait: begin
        m_axil_rready_o = 1'b1;
        if (m_axil_rvalid_i) begin
          rdata_d = m_axil_rdata_i;
          rresp_d = rsvd ? e_resp_slverr : m_axil_rresp_i;
          state_d = e_rd_send;
        end
      end
      e_rd_send: begin
        s_axi_rvalid_o = 1'b1;
        if (s_axi_rready_i) begin
          if (last_beat) state_d = e_idle;
          else begin
            burst_d.addr = next_addr;
            beat_d  = beat_q + len_width_p'(1);
            state_d = e_rd_addr;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      burst_q   <= '0;
      beat_q    <= '0;
      resp_q    <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      wr_pri_q  <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      wr_pri_q  <= wr_pri_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      error_q   <= error_d;
    end
  end

endmodule
